// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the AsyncFifo write-side arbiter and its read-side sibling.
// Pure definitions: no latency and no backpressure of its own.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STATS_W  = 32;
  localparam int PICK_MAX = 32;

  // First set bit of valid at or above start, wrapping modulo n (n <= PICK_MAX).
  function automatic int rr_pick(input logic [PICK_MAX-1:0] valid, input int start, input int n);
    int idx;
    rr_pick = start;
    for (int k = PICK_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (start + k) % n;
        if (valid[idx[4:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate by start, priority-encode lowest set bit, un-rotate. Combinational.
// No backpressure; any is low when no request is present and idx is then start.
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] start,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0] N_V = (IW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  assign any = |valid;

  always_comb begin
    dbl = {valid, valid} >> start;
    rot = dbl[N-1:0];
    off = '0;
    // Descending scan so the lowest rotated position wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, off} + {1'b0, start};
    idx = (sum >= N_V) ? IW'(sum - N_V) : IW'(sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter onto the AsyncFifo write port; beats pass combinationally, 1-cycle bubble per grant.
// wr_full stalls the granted requester indefinitely. FIFO_WR_ARB_STATS_EN adds beat_count and stall_cycles.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                       wr_clk,
  input  logic                       wr_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*BITS-1:0]    req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_wr_en,
  output logic [BITS-1:0]            fifo_wr_data,
  input  logic                       fifo_wr_full,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] beat_count,
  output logic [STATS_W-1:0]         stall_cycles
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] TOP_IDX  = IW'(NUM_REQ - 1);

  arb_state_e    state, state_nxt;
  logic [IW-1:0] grant_nxt, rr_ptr, rr_nxt, pick_idx;
  logic [CW-1:0] beat_cnt, cnt_nxt;
  logic          pick_any, in_burst, g_vld, g_last, accept;
  logic [BITS-1:0] req_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_arr[i] = req_data[i*BITS +: BITS];
  end

  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .valid (req_valid),
    .start (rr_ptr),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  assign in_burst = (state == BURST);
  assign g_vld    = req_valid[grant_idx];
  assign g_last   = req_last[grant_idx];
  // Reset cycle must never accept a beat, even if the old state was BURST.
  assign accept       = in_burst && g_vld && !fifo_wr_full && !wr_rst;
  assign fifo_wr_en   = accept;
  assign fifo_wr_data = in_burst ? req_arr[grant_idx] : '0;
  assign grant_valid  = in_burst && !wr_rst;

  always_comb begin
    req_ready = '0;
    if (in_burst && !wr_rst) req_ready[grant_idx] = !fifo_wr_full;
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    cnt_nxt   = beat_cnt;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = BURST;
          grant_nxt = pick_idx;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (accept) cnt_nxt = beat_cnt + 1'b1;
        if ((accept && (g_last || beat_cnt == LAST_CNT)) || !g_vld) begin
          state_nxt = IDLE;
          rr_nxt    = (grant_idx == TOP_IDX) ? '0 : grant_idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      beat_cnt  <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      beat_cnt  <= cnt_nxt;
      rr_ptr    <= rr_nxt;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STATS_W-1:0] beat_cnt_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    always_ff @(posedge wr_clk) begin
      if (wr_rst) beat_cnt_arr[i] <= '0;
      else if (accept && grant_idx == IW'(i)) beat_cnt_arr[i] <= beat_cnt_arr[i] + 1'b1;
    end
    assign beat_count[i*STATS_W +: STATS_W] = beat_cnt_arr[i];
  end

  // Stall = granted requester has a beat but the FIFO is full; saturates.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) stall_cycles <= '0;
    else if (in_burst && g_vld && fifo_wr_full && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: reactive requester models on two instances (MAX_BURST 8 and 2),
// per-requester expected-beat scoreboard checked on every FIFO write.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst  [2];
  logic [3:0]  rv   [2];
  logic [3:0]  rl   [2];
  logic [127:0] rd  [2];
  logic        full [2];

  logic [3:0]  rdy0, rdy1;
  logic        wen0, wen1, gv0, gv1;
  logic [31:0] wdat0, wdat1;
  logic [1:0]  gidx0, gidx1;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [127:0] bcnt0, bcnt1;
  logic [31:0]  stall0, stall1;
`endif

  logic [32:0] bq    [8][$];
  logic [31:0] exp_q [8][$];
  logic        en    [8];
  logic        acc   [8];
  int          n_chk, n_pass;

  fifo_wr_arbiter #(.BITS(32), .NUM_REQ(4), .MAX_BURST(8)) dut0 (
    .wr_clk(clk), .wr_rst(rst[0]), .req_valid(rv[0]), .req_last(rl[0]), .req_data(rd[0]),
    .req_ready(rdy0), .fifo_wr_en(wen0), .fifo_wr_data(wdat0), .fifo_wr_full(full[0]),
    .grant_valid(gv0), .grant_idx(gidx0)
`ifdef FIFO_WR_ARB_STATS_EN
    , .beat_count(bcnt0), .stall_cycles(stall0)
`endif
  );

  fifo_wr_arbiter #(.BITS(32), .NUM_REQ(4), .MAX_BURST(2)) dut1 (
    .wr_clk(clk), .wr_rst(rst[1]), .req_valid(rv[1]), .req_last(rl[1]), .req_data(rd[1]),
    .req_ready(rdy1), .fifo_wr_en(wen1), .fifo_wr_data(wdat1), .fifo_wr_full(full[1]),
    .grant_valid(gv1), .grant_idx(gidx1)
`ifdef FIFO_WR_ARB_STATS_EN
    , .beat_count(bcnt1), .stall_cycles(stall1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive every requester port from its beat queue.
  function automatic void apply();
    for (int k = 0; k < 8; k++) begin
      int m;
      int i;
      m = k / 4;
      i = k % 4;
      if (en[k] && bq[k].size() != 0) begin
        rv[m][i] = 1'b1;
        rl[m][i] = bq[k][0][32];
        rd[m][i*32 +: 32] = bq[k][0][31:0];
      end else begin
        rv[m][i] = 1'b0;
        rl[m][i] = 1'b0;
        rd[m][i*32 +: 32] = '0;
      end
    end
  endfunction

  function automatic void push_beat(input int k, input int seq, input logic last);
    logic [31:0] d;
    d = 32'hA000_0000 | (k << 16) | seq;
    bq[k].push_back({last, d});
    exp_q[k].push_back(d);
  endfunction

  function automatic void flush(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      bq[k].delete();
      exp_q[k].delete();
      en[k] = 1'b0;
    end
  endfunction

  // Requester handshake: capture acceptance mid-cycle, retire beats after the edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) acc[k] = rv[k/4][k%4] && ((k < 4) ? rdy0[k%4] : rdy1[k%4]);
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) if (acc[k] && bq[k].size() != 0) void'(bq[k].pop_front());
      apply();
    end
  end

  // Scoreboard: every FIFO write must be the next expected beat of the granted requester.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (wen0) begin
        n_chk++;
        if (exp_q[gidx0].size() == 0) $display("FAIL sb0_unexpected got %h want no write", wdat0);
        else begin
          e = exp_q[gidx0].pop_front();
          if (wdat0 !== e) $display("FAIL sb0_data got %h want %h", wdat0, e);
          else n_pass++;
        end
      end
      if (wen1) begin
        n_chk++;
        if (exp_q[4 + int'(gidx1)].size() == 0) $display("FAIL sb1_unexpected got %h want no write", wdat1);
        else begin
          e = exp_q[4 + int'(gidx1)].pop_front();
          if (wdat1 !== e) $display("FAIL sb1_data got %h want %h", wdat1, e);
          else n_pass++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int lo, input int hi, input string name);
    for (int k = lo; k <= hi; k++) begin
      n_chk++;
      if (exp_q[k].size() != 0) $display("FAIL %s_drain req%0d got %0d left want 0", name, k, exp_q[k].size());
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      n_chk++; if (rdy0 !== 4'h0 || wen0 !== 1'b0 || gv0 !== 1'b0) $display("FAIL rst0_out got %b%b%b want 000000", rdy0, wen0, gv0); else n_pass++;
      n_chk++; if (rdy1 !== 4'h0 || wen1 !== 1'b0 || gv1 !== 1'b0) $display("FAIL rst1_out got %b%b%b want 000000", rdy1, wen1, gv1); else n_pass++;
    end
    step();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    n_chk++; if (gv0 !== 1'b0 || gidx0 !== 2'd0) $display("FAIL rst_state got gv=%b idx=%0d want gv=0 idx=0", gv0, gidx0); else n_pass++;
  endtask

  task automatic test_single();
    step();
    for (int s = 0; s < 3; s++) push_beat(0, s, s == 2);
    en[0] = 1'b1;
    apply();
    @(negedge clk);
    n_chk++; if (gv0 !== 1'b0 || wen0 !== 1'b0 || wdat0 !== 32'h0) $display("FAIL single_bubble got gv=%b en=%b dat=%h want 0 0 0", gv0, wen0, wdat0); else n_pass++;
    for (int c = 1; c <= 3; c++) begin
      step();
      @(negedge clk);
      n_chk++; if (gv0 !== 1'b1 || gidx0 !== 2'd0) $display("FAIL single_grant c%0d got gv=%b idx=%0d want 1 0", c, gv0, gidx0); else n_pass++;
      n_chk++; if (wen0 !== 1'b1) $display("FAIL single_wr_en c%0d got %b want 1", c, wen0); else n_pass++;
    end
    step();
    @(negedge clk);
    n_chk++; if (gv0 !== 1'b0) $display("FAIL single_release got %b want 0", gv0); else n_pass++;
    drain(0, 0, "single");
    flush(0, 3);
  endtask

  task automatic test_gap();
    logic [2:0] exp_gv  [7];
    logic [1:0] exp_idx [7];
    logic       exp_en  [7];
    exp_gv  = '{0, 1, 1, 0, 1, 1, 0};
    exp_idx = '{0, 1, 1, 0, 2, 2, 0};
    exp_en  = '{0, 1, 0, 0, 1, 1, 0};
    step();
    push_beat(1, 0, 1'b0);
    push_beat(2, 0, 1'b0);
    push_beat(2, 1, 1'b1);
    en[1] = 1'b1;
    en[2] = 1'b1;
    apply();
    for (int c = 0; c < 7; c++) begin
      if (c != 0) step();
      @(negedge clk);
      n_chk++; if (gv0 !== exp_gv[c][0] || wen0 !== exp_en[c]) $display("FAIL gap_c%0d got gv=%b en=%b want %b %b", c, gv0, wen0, exp_gv[c][0], exp_en[c]); else n_pass++;
      if (exp_gv[c][0]) begin
        n_chk++; if (gidx0 !== exp_idx[c]) $display("FAIL gap_idx_c%0d got %0d want %0d", c, gidx0, exp_idx[c]); else n_pass++;
      end
    end
    drain(1, 2, "gap");
    flush(0, 3);
  endtask

  task automatic test_backpressure();
    step();
    for (int s = 0; s < 4; s++) push_beat(3, s, s == 3);
    en[3] = 1'b1;
    apply();
    @(negedge clk);
    n_chk++; if (gv0 !== 1'b0) $display("FAIL bp_bubble got %b want 0", gv0); else n_pass++;
    step();
    @(negedge clk);
    n_chk++; if (gidx0 !== 2'd3 || wen0 !== 1'b1) $display("FAIL bp_first got idx=%0d en=%b want 3 1", gidx0, wen0); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      step();
      full[0] = 1'b1;
      @(negedge clk);
      n_chk++; if (rdy0 !== 4'h0 || wen0 !== 1'b0) $display("FAIL bp_stall%0d got rdy=%b en=%b want 0000 0", c, rdy0, wen0); else n_pass++;
      n_chk++; if (gv0 !== 1'b1 || gidx0 !== 2'd3) $display("FAIL bp_hold%0d got gv=%b idx=%0d want 1 3", c, gv0, gidx0); else n_pass++;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      full[0] = 1'b0;
      @(negedge clk);
      n_chk++; if (wen0 !== 1'b1 || rdy0 !== 4'b1000) $display("FAIL bp_resume%0d got en=%b rdy=%b want 1 1000", c, wen0, rdy0); else n_pass++;
    end
    step();
    @(negedge clk);
    n_chk++; if (gv0 !== 1'b0) $display("FAIL bp_release got %b want 0", gv0); else n_pass++;
    drain(3, 3, "bp");
`ifdef FIFO_WR_ARB_STATS_EN
    n_chk++; if (stall0 !== 32'd5) $display("FAIL stats_stall got %0d want 5", stall0); else n_pass++;
`endif
    flush(0, 3);
  endtask

  task automatic test_reset_mid_burst();
    step();
    push_beat(1, 0, 1'b1);
    for (int s = 0; s < 4; s++) push_beat(2, s, s == 3);
    en[1] = 1'b1;
    en[2] = 1'b1;
    apply();
    for (int c = 1; c <= 3; c++) step();
    @(negedge clk);
    n_chk++; if (gidx0 !== 2'd2 || wen0 !== 1'b1) $display("FAIL rmb_beat1 got idx=%0d en=%b want 2 1", gidx0, wen0); else n_pass++;
    step();
    rst[0] = 1'b1;
    @(negedge clk);
    n_chk++; if (wen0 !== 1'b0 || rdy0 !== 4'h0) $display("FAIL rmb_rst_cycle got en=%b rdy=%b want 0 0000", wen0, rdy0); else n_pass++;
    step();
    rst[0] = 1'b0;
    flush(0, 3);
    push_beat(1, 8, 1'b1);
    push_beat(3, 8, 1'b1);
    en[1] = 1'b1;
    en[3] = 1'b1;
    apply();
    @(negedge clk);
    n_chk++; if (gv0 !== 1'b0 || rdy0 !== 4'h0) $display("FAIL rmb_idle got gv=%b rdy=%b want 0 0000", gv0, rdy0); else n_pass++;
    step();
    @(negedge clk);
    n_chk++; if (gidx0 !== 2'd1 || wen0 !== 1'b1) $display("FAIL rmb_rr_ptr got idx=%0d en=%b want 1 1", gidx0, wen0); else n_pass++;
    step();
    step();
    @(negedge clk);
    n_chk++; if (gidx0 !== 2'd3 || wen0 !== 1'b1) $display("FAIL rmb_next got idx=%0d en=%b want 3 1", gidx0, wen0); else n_pass++;
    step();
    @(negedge clk);
    drain(0, 3, "rmb");
    flush(0, 3);
  endtask

  task automatic test_fairness();
    int gn;
    int ph;
    step();
    for (int k = 4; k < 8; k++) begin
      for (int s = 0; s < 4; s++) push_beat(k, s, 1'b0);
      en[k] = 1'b1;
    end
    apply();
    @(negedge clk);
    n_chk++; if (gv1 !== 1'b0) $display("FAIL fair_bubble0 got %b want 0", gv1); else n_pass++;
    for (int c = 1; c <= 24; c++) begin
      step();
      @(negedge clk);
      ph = (c - 1) % 3;
      gn = (c - 1) / 3;
      if (ph < 2) begin
        n_chk++; if (gv1 !== 1'b1 || gidx1 !== 2'(gn % 4) || wen1 !== 1'b1) $display("FAIL fair_c%0d got gv=%b idx=%0d en=%b want 1 %0d 1", c, gv1, gidx1, wen1, gn % 4); else n_pass++;
      end else begin
        n_chk++; if (gv1 !== 1'b0 || wen1 !== 1'b0) $display("FAIL fair_gap_c%0d got gv=%b en=%b want 0 0", c, gv1, wen1); else n_pass++;
      end
    end
    drain(4, 7, "fair");
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (bcnt1[i*32 +: 32] !== 32'd4) $display("FAIL stats_beats req%0d got %0d want 4", i, bcnt1[i*32 +: 32]); else n_pass++;
    end
    n_chk++; if (stall1 !== 32'd0) $display("FAIL stats_stall1 got %0d want 0", stall1); else n_pass++;
`endif
    flush(4, 7);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    full[0] = 1'b0;
    full[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      en[k]  = 1'b0;
      acc[k] = 1'b0;
    end
    apply();
    test_reset();
    test_single();
    test_gap();
    test_backpressure();
    test_reset_mid_burst();
    test_fairness();
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
